// File: rtl/irq_nest_ctrl.sv
// rtl/irq_nest_ctrl.sv - nested interrupt sequencer between HETIC and core, with a handler-level stack.
// Optional HETIC_NEST_STATS_EN adds preemption count and maximum depth outputs.
module irq_nest_ctrl #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int StackDepth = 8,
  localparam int IrqWidth   = $clog2(NrIrqLines),
  localparam int PrioWidth  = $clog2(NrIrqPrios),
  localparam int DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hetic_valid_i,
  input  logic [IrqWidth-1:0]   hetic_id_i,
  input  logic [PrioWidth-1:0]  hetic_level_i,
  input  logic                  hetic_heti_i,
  input  logic                  hetic_nest_i,
  output logic                  hetic_ack_o,
  output logic [IrqWidth-1:0]   hetic_ack_id_o,
  output logic                  core_irq_o,
  output logic [IrqWidth-1:0]   core_id_o,
  output logic                  core_heti_o,
  output logic [PrioWidth-1:0]  core_level_o,
  input  logic                  core_take_i,
  input  logic                  core_mret_i,
  output logic [PrioWidth-1:0]  threshold_o,
  output logic [DepthWidth-1:0] depth_o,
`ifdef HETIC_NEST_STATS_EN
  output logic [31:0]           preempt_cnt_o,
  output logic [DepthWidth-1:0] max_depth_o,
`endif
  output logic                  mret_err_o
);

  localparam int IdxWidth = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam logic [DepthWidth-1:0] FullDepth = DepthWidth'(StackDepth);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

  state_e state_q, state_d;

  logic [IrqWidth-1:0]   stk_id_q    [StackDepth];
  logic [PrioWidth-1:0]  stk_level_q [StackDepth];
  logic                  stk_nest_q  [StackDepth];
  logic [DepthWidth-1:0] depth_q, depth_d, depth_pop;
  logic                  mret_err_q, mret_err_d;

  logic [IrqWidth-1:0]   core_id_q;
  logic [PrioWidth-1:0]  core_level_q;
  logic                  core_heti_q;
  logic                  core_nest_q;

  logic                  empty, top_nest, eligible, latch_en, do_push, push_ok, do_pop;
  logic [IdxWidth-1:0]   top_idx, push_idx;

  assign empty       = (depth_q == '0);
  assign top_idx     = IdxWidth'(depth_q - 1'b1);
  assign threshold_o = empty ? '0 : stk_level_q[top_idx];
  assign top_nest    = empty ? 1'b1 : stk_nest_q[top_idx];
  assign eligible    = hetic_valid_i && (hetic_level_i > threshold_o) && top_nest
                       && (depth_q != FullDepth);

  // Pop is applied before push so an mret in the ACK cycle replaces the top entry.
  assign do_pop     = core_mret_i && !empty;
  assign depth_pop  = do_pop ? depth_q - 1'b1 : depth_q;
  assign push_ok    = do_push && (depth_pop != FullDepth);
  assign push_idx   = IdxWidth'(depth_pop);
  assign depth_d    = push_ok ? depth_pop + 1'b1 : depth_pop;
  assign mret_err_d = mret_err_q || (core_mret_i && empty);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          latch_en = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (core_take_i) begin
          state_d = ACK;
        end else if (eligible && (hetic_level_i > core_level_q)) begin
          latch_en = 1'b1;
        end else if (!hetic_valid_i || (hetic_level_i <= threshold_o)) begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_irq_o  = (state_q == REQ);
    hetic_ack_o = (state_q == ACK);
    do_push     = (state_q == ACK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_id_q    <= '0;
      core_level_q <= '0;
      core_heti_q  <= 1'b0;
      core_nest_q  <= 1'b0;
    end else if (latch_en) begin
      core_id_q    <= hetic_id_i;
      core_level_q <= hetic_level_i;
      core_heti_q  <= hetic_heti_i;
      core_nest_q  <= hetic_nest_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < StackDepth; i++) begin
        stk_id_q[i]    <= '0;
        stk_level_q[i] <= '0;
        stk_nest_q[i]  <= 1'b0;
      end
      depth_q    <= '0;
      mret_err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        stk_id_q[push_idx]    <= core_id_q;
        stk_level_q[push_idx] <= core_level_q;
        stk_nest_q[push_idx]  <= core_nest_q;
      end
      depth_q    <= depth_d;
      mret_err_q <= mret_err_d;
    end
  end

  assign hetic_ack_id_o = core_id_q;
  assign core_id_o      = core_id_q;
  assign core_level_o   = core_level_q;
  assign core_heti_o    = core_heti_q;
  assign depth_o        = depth_q;
  assign mret_err_o     = mret_err_q;

`ifdef HETIC_NEST_STATS_EN
  logic [31:0]           preempt_cnt_q;
  logic [DepthWidth-1:0] max_depth_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      preempt_cnt_q <= '0;
      max_depth_q   <= '0;
    end else begin
      if (push_ok && !empty && (preempt_cnt_q != '1)) begin
        preempt_cnt_q <= preempt_cnt_q + 32'd1;
      end
      if (depth_d > max_depth_q) begin
        max_depth_q <= depth_d;
      end
    end
  end

  assign preempt_cnt_o = preempt_cnt_q;
  assign max_depth_o   = max_depth_q;
`endif

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb/tb_irq_nest_ctrl.sv - directed bench for irq_nest_ctrl with a transaction-level stack model.
module tb_irq_nest_ctrl;

  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0, heti = 1'b0, nest = 1'b0, take = 1'b0, mret = 1'b0;
  logic [5:0] id = '0;
  logic [4:0] lvl = '0;
  logic       ack, irq, c_heti, err;
  logic [5:0] ack_id, c_id;
  logic [4:0] c_lvl, thr;
  logic [1:0] depth;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [5:0] id;
    logic [4:0] lvl;
    logic       nest;
  } ent_t;

  ent_t       m_stk[$];
  bit         m_req, m_ack, m_err;
  logic [5:0] l_id;
  logic [4:0] l_lvl;
  logic       l_heti, l_nest;

  irq_nest_ctrl #(.NrIrqLines(64), .NrIrqPrios(32), .StackDepth(SD)) dut (
    .clk_i(clk), .rst_i(rst),
    .hetic_valid_i(v), .hetic_id_i(id), .hetic_level_i(lvl),
    .hetic_heti_i(heti), .hetic_nest_i(nest),
    .hetic_ack_o(ack), .hetic_ack_id_o(ack_id),
    .core_irq_o(irq), .core_id_o(c_id), .core_heti_o(c_heti), .core_level_o(c_lvl),
    .core_take_i(take), .core_mret_i(mret),
    .threshold_o(thr), .depth_o(depth), .mret_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_thr();
    return (m_stk.size() == 0) ? 0 : int'(m_stk[$].lvl);
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_req = 0; m_ack = 0; m_err = 0;
    l_id = '0; l_lvl = '0; l_heti = 1'b0; l_nest = 1'b0;
  endtask

  task automatic model_step();
    int  thr_now = m_thr();
    bit  tn      = (m_stk.size() == 0) ? 1'b1 : m_stk[$].nest;
    bit  elig    = v && (int'(lvl) > thr_now) && tn && (m_stk.size() < SD);
    bit  was_ack = m_ack;
    m_ack = 0;
    if (mret) begin
      if (m_stk.size() == 0) m_err = 1;
      else void'(m_stk.pop_back());
    end
    if (was_ack) begin
      if (m_stk.size() < SD) m_stk.push_back('{id: l_id, lvl: l_lvl, nest: l_nest});
    end else if (m_req) begin
      if (take) begin
        m_req = 0; m_ack = 1;
      end else if (elig && (lvl > l_lvl)) begin
        l_id = id; l_lvl = lvl; l_heti = heti; l_nest = nest;
      end else if (!v || (int'(lvl) <= thr_now)) begin
        m_req = 0;
      end
    end else if (elig) begin
      l_id = id; l_lvl = lvl; l_heti = heti; l_nest = nest;
      m_req = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      if (!rst) begin
        chk("core_irq", irq, m_req);
        chk("hetic_ack", ack, m_ack);
        if (m_ack) chk("ack_id", ack_id, l_id);
        chk("core_id", c_id, l_id);
        chk("core_level", c_lvl, l_lvl);
        chk("core_heti", c_heti, l_heti);
        chk("threshold", thr, m_thr());
        chk("depth", depth, m_stk.size());
        chk("mret_err", err, m_err);
      end
    end
  end

  task automatic cyc(input bit iv, input int iid, input int il, input bit ih,
                     input bit in_, input bit it, input bit im);
    @(negedge clk);
    v = iv; id = 6'(iid); lvl = 5'(il); heti = ih; nest = in_; take = it; mret = im;
    @(posedge clk);
    #2;
  endtask

  task automatic deliver(input int iid, input int il, input bit ih, input bit in_);
    cyc(1, iid, il, ih, in_, 0, 0);
    cyc(1, iid, il, ih, in_, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #12;
    chk("reset_irq", irq, 0);
    chk("reset_depth", depth, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic delivery
    cyc(1, 5, 3, 1, 1, 0, 0);
    chk("basic_irq", irq, 1);
    chk("basic_id", c_id, 5);
    cyc(1, 5, 3, 1, 1, 1, 0);
    chk("basic_ack", ack, 1);
    chk("basic_ack_id", ack_id, 5);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("basic_depth", depth, 1);
    chk("basic_thr", thr, 3);

    // equal level does not preempt
    cyc(1, 2, 3, 0, 1, 0, 0);
    cyc(1, 2, 3, 0, 1, 0, 0);
    chk("equal_no_irq", irq, 0);

    // preemption to depth 2
    deliver(9, 7, 0, 1);
    chk("preempt_depth", depth, 2);
    chk("preempt_thr", thr, 7);

    // full stack blocks everything
    cyc(1, 1, 31, 0, 1, 0, 0);
    cyc(1, 1, 31, 0, 1, 1, 0);
    chk("full_no_irq", irq, 0);
    chk("full_no_ack", ack, 0);

    // three returns, third underflows
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("mret1_thr", thr, 3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("mret2_depth", depth, 0);
    chk("mret2_err", err, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("mret3_depth", depth, 0);
    chk("mret3_err", err, 1);

    // non-nestable top entry
    deliver(3, 5, 0, 0);
    cyc(1, 4, 20, 1, 1, 0, 0);
    cyc(1, 4, 20, 1, 1, 0, 0);
    chk("nonnest_blocked", irq, 0);
    cyc(1, 4, 20, 1, 1, 0, 1);
    chk("nonnest_mret_cycle", irq, 0);
    cyc(1, 4, 20, 1, 1, 0, 0);
    chk("nonnest_after_mret", irq, 1);
    chk("nonnest_id", c_id, 4);

    // withdraw, then request and re-latch
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("withdraw_irq", irq, 0);
    cyc(1, 5, 3, 0, 1, 0, 0);
    chk("relatch_first", c_id, 5);
    cyc(1, 8, 6, 0, 1, 0, 0);
    chk("relatch_id", c_id, 8);
    chk("relatch_lvl", c_lvl, 6);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drop_irq", irq, 0);
    chk("drop_no_ack", ack, 0);

    // take outside REQ is ignored
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idle_take_no_ack", ack, 0);

    // mret during ACK replaces top entry
    deliver(5, 3, 0, 1);
    cyc(1, 9, 7, 0, 1, 0, 0);
    cyc(1, 9, 7, 0, 1, 1, 0);
    chk("sim_ack", ack, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("sim_depth", depth, 1);
    chk("sim_thr", thr, 7);

    // asynchronous reset in REQ
    cyc(1, 11, 10, 0, 1, 0, 0);
    chk("pre_rst_irq", irq, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    v = 1'b0;
    #1;
    chk("async_rst_irq", irq, 0);
    chk("async_rst_depth", depth, 0);
    chk("async_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_nest_ctrl.md
Name: irq_nest_ctrl

Overview:
- Sequences interrupt delivery between the heterogeneous interrupt controller (HETIC) and the core.
- Holds a hardware stack of active handler levels and derives the current preemption threshold.
- Decides whether the HETIC arbiter winner may interrupt the core, latches it, and waits for the core to take it.
- Then issues the claim/ack back to HETIC so the pending bit clears; pops the stack on handler return.

Parameters:
- NrIrqLines, 64, number of interrupt lines; IrqWidth = $clog2(NrIrqLines)
- NrIrqPrios, 32, number of priority levels; PrioWidth = $clog2(NrIrqPrios)
- StackDepth, 8, max nesting depth (>=1); DepthWidth = $clog2(StackDepth+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- hetic_valid_i  in  1  arbiter winner valid
- hetic_id_i  in  IrqWidth  arbiter winner id
- hetic_level_i  in  PrioWidth  winner priority
- hetic_heti_i  in  1  winner is a HETI line
- hetic_nest_i  in  1  winner handler may itself be preempted
- hetic_ack_o  out  1  claim pulse to HETIC
- hetic_ack_id_o  out  IrqWidth  id being claimed
- core_irq_o  out  1  interrupt request to core
- core_id_o  out  IrqWidth  latched id
- core_heti_o  out  1  latched heti flag
- core_level_o  out  PrioWidth  latched level
- core_take_i  in  1  core accepts the request (handler entry)
- core_mret_i  in  1  core handler return
- threshold_o  out  PrioWidth  level on top of stack, 0 if empty
- depth_o  out  DepthWidth  current nesting depth
- mret_err_o  out  1  sticky: mret with empty stack

Behaviour:
- Reset is asynchronous, active-high. All outputs, the stack and the FSM reset to 0 / IDLE.
- Stack entry holds {id, level, nest}. threshold_o and top_nest are taken from the top entry. With an empty stack, threshold_o = 0 and top_nest = 1.
- Level 0 never interrupts; comparisons are unsigned.
- eligible = hetic_valid_i & (hetic_level_i > threshold_o) & top_nest & (depth_o != StackDepth).
- FSM states:
  - IDLE: when eligible, latch id/level/heti/nest into core_* registers and go to REQ. core_irq_o is asserted from the next cycle (registered).
  - REQ: core_irq_o = 1.
    - If core_take_i: go to ACK.
    - Else if eligible and hetic_level_i > latched level: re-latch, stay in REQ.
    - Else if !hetic_valid_i, or hetic_level_i <= threshold_o: withdraw, core_irq_o = 0 next cycle, go to IDLE.
  - ACK: single cycle. hetic_ack_o = 1 with hetic_ack_id_o = latched id. Push the latched entry, increment depth, deassert core_irq_o, go to IDLE.
- Request-to-ack latency: hetic_ack_o rises exactly 1 cycle after the core_take_i cycle.
- core_mret_i is accepted in any state and pops 1 entry in that cycle.
- If core_mret_i arrives in the ACK cycle, the pop is applied first, then the push; depth is unchanged and the top entry is replaced.
- core_mret_i with depth 0: no pop, set mret_err_o (sticky until reset).
- Full stack: eligible is forced to 0, so no request is raised. A latched REQ is never pushed beyond StackDepth.
- Outside REQ, core_take_i is ignored.
- After an mret in REQ, eligibility is re-evaluated against the new threshold on the next cycle.

Optional Feature:
- Macro: HETIC_NEST_STATS_EN.
- Defined: adds outputs preempt_cnt_o (32 bit) and max_depth_o (DepthWidth).
  - preempt_cnt_o increments on every push made while depth_o != 0, and saturates at all-ones.
  - max_depth_o is a running maximum of depth_o.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Basic delivery: valid, id 5, level 3, depth 0 → core_irq_o=1 next cycle, core_id_o=5. Then take → hetic_ack_o pulse with id 5 one cycle later; depth_o=1, threshold_o=3.
- Preemption: depth 1 at level 3 with nest=1; id 9 arrives at level 7 → request and push; depth 2, threshold 7. Next, id 2 at level 7 → no request, since equality does not preempt.
- Non-nestable top: top entry has nest=0; id 4 at level 20 → core_irq_o stays 0 until mret, then asserted 1 cycle after mret.
- Withdraw and re-latch:
  - In REQ with id 5 at level 3, id 8 at level 6 appears → core_id_o=8.
  - Dropping hetic_valid_i → core_irq_o=0 next cycle, no hetic_ack_o.
- Full and error:
  - StackDepth=2 with 2 entries → any level gives no request.
  - 3 mrets → depth 0, and mret_err_o=1 after the third.
- Simultaneous and reset:
  - core_mret_i in the ACK cycle → depth unchanged, top replaced by the new entry.
  - Asserting rst_i mid-REQ → core_irq_o=0 immediately, asynchronously.
